// File: rtl/proc_datapath.sv
// proc_datapath: multi-cycle processor datapath (PC, IR, 4x register file,
// R1/R2 operand latches, MDR, ALUOut, ALU, N/Z flags).
//
// Ports:
//   clock, reset          - clock; async active-high reset clears all state
//   PCwrite .. FlagWrite  - single-bit control strobes from the control FSM
//   ALU2 [2:0]            - ALU operand-B select
//   ALUop [2:0]           - ALU operation
//   mem_addr/wdata/we/re  - unified memory request (combinational)
//   mem_rdata             - memory read data, valid in the same cycle
//   instr [3:0]           - IR[3:0], opcode back to the FSM
//   N, Z                  - flag registers
//
// Optional: define DATAPATH_DBG_EN to add read-only debug ports
//   dbg_sel [1:0] (in), dbg_rf = RF[dbg_sel], dbg_pc = PC.

module proc_datapath #(
    parameter int                DATA_W   = 8,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              PCwrite,
    input  logic              AddrSel,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IRload,
    input  logic              R1Sel,
    input  logic              MDRload,
    input  logic              R1R2Load,
    input  logic              ALU1,
    input  logic              ALUOutWrite,
    input  logic              RFWrite,
    input  logic              RegIn,
    input  logic              FlagWrite,
    input  logic [2:0]        ALU2,
    input  logic [2:0]        ALUop,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        instr,
    output logic              N,
    output logic              Z
`ifdef DATAPATH_DBG_EN
    ,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_rf,
    output logic [DATA_W-1:0] dbg_pc
`endif
);

    localparam logic [2:0] B_R2   = 3'b000;
    localparam logic [2:0] B_ONE  = 3'b001;
    localparam logic [2:0] B_SIMM = 3'b010;
    localparam logic [2:0] B_IMM5 = 3'b011;
    localparam logic [2:0] B_IMM3 = 3'b100;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_SHF  = 3'b100;

    logic [DATA_W-1:0] pc, ir, mdr, r1, r2, alu_out;
    logic [DATA_W-1:0] rf [4];
    logic [1:0]        rx, ry;
    logic [DATA_W-1:0] op_a, op_b, alu_res;

    // R1Sel forces the destination/first source to R1 for immediate forms.
    assign rx = R1Sel ? 2'd1 : ir[7:6];
    assign ry = ir[5:4];

    assign mem_addr  = AddrSel ? pc : r2;
    assign mem_wdata = r1;
    assign mem_we    = MemWrite;
    assign mem_re    = MemRead;
    assign instr     = ir[3:0];

    assign op_a = ALU1 ? r1 : pc;

    always_comb begin
        op_b = '0;
        case (ALU2)
            B_R2:    op_b = r2;
            B_ONE:   op_b = DATA_W'(1);
            B_SIMM:  op_b = {{(DATA_W-4){ir[7]}}, ir[7:4]};
            B_IMM5:  op_b = {{(DATA_W-5){1'b0}}, ir[7:3]};
            B_IMM3:  op_b = {{(DATA_W-3){1'b0}}, ir[5:3]};
            default: op_b = '0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (ALUop)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_NAND: alu_res = ~(op_a & op_b);
            // B[2] picks direction, B[1:0] the distance (0..3).
            OP_SHF:  alu_res = op_b[2] ? (op_a << op_b[1:0]) : (op_a >> op_b[1:0]);
            default: alu_res = '0;
        endcase
    end

    // Every enable is independent; RF reads for R1/R2 see the pre-write
    // contents when RFWrite and R1R2Load coincide (no bypass).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            r1      <= '0;
            r2      <= '0;
            alu_out <= '0;
            N       <= 1'b0;
            Z       <= 1'b0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else begin
            if (PCwrite)     pc      <= alu_res;
            if (IRload)      ir      <= mem_rdata;
            if (MDRload)     mdr     <= mem_rdata;
            if (ALUOutWrite) alu_out <= alu_res;
            if (R1R2Load) begin
                r1 <= rf[rx];
                r2 <= rf[ry];
            end
            if (RFWrite)     rf[rx]  <= RegIn ? mdr : alu_out;
            if (FlagWrite) begin
                N <= alu_res[DATA_W-1];
                Z <= (alu_res == '0);
            end
        end
    end

`ifdef DATAPATH_DBG_EN
    assign dbg_rf = rf[dbg_sel];
    assign dbg_pc = pc;
`endif

endmodule

// File: doc/proc_datapath.md
Name: proc_datapath

Overview:
- Multi-cycle processor datapath: PC, IR, 4-entry register file, R1/R2 operand latches, MDR, ALUOut, ALU and N/Z flag register.
- Sits directly downstream of the control FSM and consumes all of its control strobes.
- Feeds back instr[3:0], N and Z to the FSM, and drives the unified instruction/data memory port.

Parameters:
- DATA_W, 8, width of PC, IR, registers, ALU and memory data.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load, ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite  in  1 each  FSM control strobes.
- ALU2  in  3  ALU operand-B select.
- ALUop  in  3  ALU operation.
- mem_addr  out  DATA_W  memory address (combinational).
- mem_wdata  out  DATA_W  store data = R1 (combinational).
- mem_we  out  1  = MemWrite (combinational).
- mem_re  out  1  = MemRead (combinational).
- mem_rdata  in  DATA_W  memory read data; asynchronous read, valid in the same cycle.
- instr  out  4  IR[3:0], opcode to FSM.
- N  out  1  negative flag register.
- Z  out  1  zero flag register.

Behaviour:
- Reset (async): PC=RESET_PC; IR, MDR, R1, R2, ALUOut, RF[0..3], N, Z = 0. Outputs follow immediately. Reset mid-instruction discards all in-flight values.
- Register index: rx = R1Sel ? 2'd1 : IR[7:6]; ry = IR[5:4].
- mem_addr = AddrSel ? PC : R2.
- ALU operand A = ALU1 ? R1 : PC.
- ALU operand B by ALU2:
  - 000: R2
  - 001: constant 1
  - 010: sign-extended IR[7:4]
  - 011: zero-extended IR[7:3]
  - 100: zero-extended IR[5:3]
  - 101-111: 0
- ALUop:
  - 000: A+B
  - 001: A-B
  - 010: A|B
  - 011: ~(A&B)
  - 100: shift A by B[1:0]; left if B[2]=1, else logical right
  - 101-111: result 0
- Arithmetic is modulo 2^DATA_W; carry/overflow are discarded.
- Posedge updates; each enable is independent, and several may be active in one cycle:
  - PCwrite: PC <= ALU result.
  - IRload: IR <= mem_rdata.
  - MDRload: MDR <= mem_rdata.
  - R1R2Load: R1 <= RF[rx], R2 <= RF[ry].
  - ALUOutWrite: ALUOut <= ALU result.
  - RFWrite: RF[rx] <= RegIn ? MDR : ALUOut.
  - FlagWrite: N <= result[DATA_W-1], Z <= (result==0).
- No write-to-read bypass. With RFWrite and R1R2Load in the same cycle, R1/R2 capture the pre-write RF value.
- Single-cycle latency: any strobe asserted in cycle t has its effect visible in cycle t+1. Fetch (PCwrite+IRload, ALU1=0, ALU2=001) yields IR=mem[PC] and PC=PC+1 in one cycle.
- Branch target = incremented PC + sext(IR[7:4]). PC wraps 0xFF->0x00 with no fault.
- Flags change only on FlagWrite. PCwrite, ALUOutWrite and load paths never touch N/Z.
- With all strobes low (e.g. FSM stop state) all state holds indefinitely.

Optional Feature:
- Macro: DATAPATH_DBG_EN.
- Defined: adds ports dbg_sel (in, 2), dbg_rf (out, DATA_W) = RF[dbg_sel] combinational, and dbg_pc (out, DATA_W) = PC. These ports are read-only and must not perturb datapath timing or state.
- Undefined: the ports are absent and the block has no debug logic.

Test Plan:
- Reset during a fetch with mem_rdata=0xA5 and IRload=1 -> after reset: PC=0, IR=0, instr=0, N=0, Z=0, RF all 0; IR stays 0.
- Fetch with PC=0x10, mem_rdata=0x64, PCwrite=IRload=AddrSel=1, ALU2=001 -> next cycle PC=0x11, IR=0x64, instr=0x4, mem_addr was 0x10 during the fetch.
- RF[1]=0x05, RF[2]=0x05, IR=0x66 (sub R1,R2): R1R2Load, then ALU1=1, ALUop=001, ALUOutWrite, FlagWrite, then RFWrite -> RF[1]=0x00, Z=1, N=0.
- Load: IR=0x40, RF[0]=0x33 in R2, AddrSel=0, mem_rdata=0x80, MDRload; then RFWrite+RegIn -> RF[1]=0x80, mem_addr was 0x33, flags unchanged.
- Branch: PC=0x20, IR=0xE5 (imm=-2), ALU2=010, PCwrite -> PC=0x1E. PC=0xFF with fetch increment -> PC=0x00.
- ORI: RF[1]=0x40, IR=0x2F (imm5=0x05), R1Sel=1 path, ALUop=010, ALU2=011 -> RF[1]=0x45, N=0, Z=0. Under DATAPATH_DBG_EN with dbg_sel=1 -> dbg_rf=0x45.
